// File: rtl/flight_pkg.sv
// Shared Saturn V flight constants, sequencer state encoding and per-phase table lookups.
// Reused by every flight block that needs stage masses, Isp or burn times.
package flight_pkg;

  localparam int unsigned N = 64;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_BURN  = 3'd2,
    ST_SEP   = 3'd3,
    ST_DONE  = 3'd4,
    ST_FAULT = 3'd5
  } seq_state_e;

  localparam logic [3:0]   STAGE_IDLE  = 4'd0;
  localparam logic [3:0]   STAGE_FAULT = 4'd15;
  localparam logic [N-1:0] ONE_N       = 64'd1;

  localparam logic [31:0] ISP_1  = 32'd263;
  localparam logic [31:0] ISP_2  = 32'd421;
  localparam logic [31:0] ISP_3  = 32'd421;
  localparam logic [31:0] PROP_1 = 32'd2077000;
  localparam logic [31:0] PROP_2 = 32'd456100;
  localparam logic [31:0] PROP_3 = 32'd39136;
  localparam logic [31:0] PROP_4 = 32'd83864;
  localparam logic [31:0] BURN_1 = 32'd168;
  localparam logic [31:0] BURN_2 = 32'd360;
  localparam logic [31:0] BURN_3 = 32'd165;
  localparam logic [31:0] BURN_4 = 32'd335;
  localparam logic [31:0] DRY_1  = 32'd137000;
  localparam logic [31:0] DRY_2  = 32'd40100;
  localparam logic [31:0] DRY_3  = 32'd15200;
  localparam logic [31:0] LM     = 32'd15103;
  localparam logic [31:0] CMSM   = 32'd11900;

  // Phase 4 is the S-IVB re-ignition: only phase-3 propellant is gone, no dry mass dropped.
  localparam logic [31:0] MASS_4 = DRY_3 + PROP_4 + LM + CMSM;
  localparam logic [31:0] MASS_3 = MASS_4 + PROP_3;
  localparam logic [31:0] MASS_2 = MASS_3 + DRY_2 + PROP_2;
  localparam logic [31:0] MASS_1 = MASS_2 + DRY_1 + PROP_1;

  function automatic logic [31:0] phase_isp(input logic [2:0] phase);
    case (phase)
      3'd1:       phase_isp = ISP_1;
      3'd2:       phase_isp = ISP_2;
      3'd3, 3'd4: phase_isp = ISP_3;
      default:    phase_isp = 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] phase_mass(input logic [2:0] phase);
    case (phase)
      3'd1:    phase_mass = MASS_1;
      3'd2:    phase_mass = MASS_2;
      3'd3:    phase_mass = MASS_3;
      3'd4:    phase_mass = MASS_4;
      default: phase_mass = 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] phase_prop(input logic [2:0] phase);
    case (phase)
      3'd1:    phase_prop = PROP_1;
      3'd2:    phase_prop = PROP_2;
      3'd3:    phase_prop = PROP_3;
      3'd4:    phase_prop = PROP_4;
      default: phase_prop = 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] phase_burn(input logic [2:0] phase);
    case (phase)
      3'd1:    phase_burn = BURN_1;
      3'd2:    phase_burn = BURN_2;
      3'd3:    phase_burn = BURN_3;
      3'd4:    phase_burn = BURN_4;
      default: phase_burn = 32'd1;
    endcase
  endfunction

endpackage

// File: rtl/stage_sequencer_if.sv
// Sequencer <-> launch control / velocity calculator signal bundle.
// master = the sequencer; slave = whoever drives launch/abort/ignition_end.
interface stage_sequencer_if;
  import flight_pkg::*;

  logic         launch;
  logic         abort;
  logic         ignition_end;
  logic         calc_resetb;
  logic [N-1:0] specific_impulse;
  logic [N-1:0] initial_weight;
  logic [N-1:0] propellant_weight;
  logic [N-1:0] burntime;
  logic [3:0]   stage_state;
  logic         burning;
  logic         separate_pulse;
  logic         leo_pulse;
  logic         mission_done;
  logic         fault;
  logic [N-1:0] mission_sec;

  modport master (
    input  launch, abort, ignition_end,
    output calc_resetb, specific_impulse, initial_weight, propellant_weight, burntime,
           stage_state, burning, separate_pulse, leo_pulse, mission_done, fault, mission_sec
  );

  modport slave (
    output launch, abort, ignition_end,
    input  calc_resetb, specific_impulse, initial_weight, propellant_weight, burntime,
           stage_state, burning, separate_pulse, leo_pulse, mission_done, fault, mission_sec
  );
endinterface

// File: rtl/mission_clock.sv
// Tick divider producing whole-second mission and phase counters.
// clr_all_i zeroes everything, clr_phase_i restarts only the phase seconds; en_i low freezes all.
module mission_clock #(
  parameter int unsigned TICKS_PER_SEC = 50,
  parameter int unsigned W             = 64
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en_i,
  input  logic         clr_all_i,
  input  logic         clr_phase_i,
  output logic [W-1:0] mission_sec_o,
  output logic [W-1:0] phase_sec_o
);
  localparam int unsigned    TW       = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [TW-1:0]  TICK_MAX = TW'(TICKS_PER_SEC - 1);
  localparam logic [TW-1:0]  TICK_ONE = TW'(1);
  localparam logic [W-1:0]   SEC_ONE  = W'(1);

  logic [TW-1:0] tick_q;
  logic [W-1:0]  mission_sec_q;
  logic [W-1:0]  phase_sec_q;
  logic          wrap_s;

  assign wrap_s = en_i && (tick_q == TICK_MAX);

  // Tick divider and second counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_q        <= '0;
      mission_sec_q <= '0;
      phase_sec_q   <= '0;
    end else if (clr_all_i) begin
      tick_q        <= '0;
      mission_sec_q <= '0;
      phase_sec_q   <= '0;
    end else begin
      if (wrap_s) begin
        tick_q        <= '0;
        mission_sec_q <= mission_sec_q + SEC_ONE;
      end else if (en_i) begin
        tick_q        <= tick_q + TICK_ONE;
      end
      if (clr_phase_i) begin
        phase_sec_q <= '0;
      end else if (wrap_s) begin
        phase_sec_q <= phase_sec_q + SEC_ONE;
      end
    end
  end

  assign mission_sec_o = mission_sec_q;
  assign phase_sec_o   = phase_sec_q;
endmodule

// File: rtl/stage_sequencer.sv
// Flight-phase sequencer: loads per-phase stage parameters and restarts the velocity calculator.
// Optional burn watchdog enabled by defining STAGE_SEQ_WATCHDOG_EN.
module stage_sequencer
  import flight_pkg::*;
#(
  parameter int unsigned TICKS_PER_SEC = 50,
  parameter int unsigned SEP_CYCLES    = 2,
  parameter int unsigned WDOG_SLACK    = 5
) (
  input logic               clk,
  input logic               resetb,
  stage_sequencer_if.master bus
);
  localparam int unsigned   SW       = (SEP_CYCLES > 1) ? $clog2(SEP_CYCLES) : 1;
  localparam logic [SW-1:0] SEP_LAST = SW'(SEP_CYCLES - 1);
  localparam logic [SW-1:0] SEP_ONE  = SW'(1);

  seq_state_e    state_q, state_d;
  logic [2:0]    phase_q, phase_d;
  logic [SW-1:0] sep_cnt_q, sep_cnt_d;
  logic          burn_arm_q, burn_arm_d;

  logic          calc_resetb_q, calc_resetb_d;
  logic [N-1:0]  isp_q, isp_d;
  logic [N-1:0]  weight_q, weight_d;
  logic [N-1:0]  prop_q, prop_d;
  logic [N-1:0]  burntime_q, burntime_d;
  logic [3:0]    stage_q, stage_d;
  logic          burning_q, burning_d;
  logic          sep_pulse_q, sep_pulse_d;
  logic          leo_pulse_q, leo_pulse_d;
  logic          done_q, done_d;
  logic          fault_q, fault_d;

  logic [N-1:0]  mission_sec_s;
  logic [N-1:0]  phase_sec_s;
  logic          wdog_trip_s;

`ifdef STAGE_SEQ_WATCHDOG_EN
  assign wdog_trip_s = phase_sec_s > (burntime_q + N'(WDOG_SLACK));
`else
  logic [N-1:0] unused_wdog_s;
  assign wdog_trip_s   = 1'b0;
  assign unused_wdog_s = phase_sec_s ^ N'(WDOG_SLACK);
`endif

  mission_clock #(
    .TICKS_PER_SEC (TICKS_PER_SEC),
    .W             (N)
  ) u_clock (
    .clk           (clk),
    .rst_n         (resetb),
    .en_i          ((state_q == ST_LOAD) || (state_q == ST_BURN) || (state_q == ST_SEP)),
    .clr_all_i     (state_q == ST_IDLE),
    .clr_phase_i   (state_q == ST_LOAD),
    .mission_sec_o (mission_sec_s),
    .phase_sec_o   (phase_sec_s)
  );

  // Next-state logic; abort outranks every other event.
  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    sep_cnt_d = sep_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.launch) begin
          state_d = ST_LOAD;
          phase_d = 3'd1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LOAD: begin
        if (bus.abort) state_d = ST_FAULT;
        else           state_d = ST_BURN;
      end
      ST_BURN: begin
        // burn_arm_q masks the calculator's stale completion in the first BURN cycle.
        if (bus.abort) begin
          state_d = ST_FAULT;
        end else if (wdog_trip_s) begin
          state_d = ST_FAULT;
        end else if (burn_arm_q && bus.ignition_end) begin
          state_d   = ST_SEP;
          sep_cnt_d = {SW{1'b0}};
        end else begin
          state_d = ST_BURN;
        end
      end
      ST_SEP: begin
        if (bus.abort) begin
          state_d = ST_FAULT;
        end else if (sep_cnt_q == SEP_LAST) begin
          if (phase_q == 3'd4) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_LOAD;
            phase_d = phase_q + 3'd1;
          end
        end else begin
          sep_cnt_d = sep_cnt_q + SEP_ONE;
        end
      end
      ST_DONE:  state_d = ST_DONE;
      ST_FAULT: state_d = ST_FAULT;
      default:  state_d = ST_FAULT;
    endcase
  end

  assign burn_arm_d = (state_q == ST_BURN) && (state_d == ST_BURN);

  // Output values for the state being entered, so they register together with it.
  always_comb begin
    calc_resetb_d = calc_resetb_q;
    isp_d         = isp_q;
    weight_d      = weight_q;
    prop_d        = prop_q;
    burntime_d    = burntime_q;
    stage_d       = stage_q;
    burning_d     = 1'b0;
    sep_pulse_d   = 1'b0;
    leo_pulse_d   = 1'b0;
    done_d        = 1'b0;
    fault_d       = 1'b0;
    case (state_d)
      ST_IDLE: begin
        calc_resetb_d = 1'b0;
        isp_d         = '0;
        weight_d      = '0;
        prop_d        = '0;
        burntime_d    = ONE_N;
        stage_d       = STAGE_IDLE;
      end
      ST_LOAD: begin
        calc_resetb_d = 1'b0;
        isp_d         = N'(phase_isp(phase_d));
        weight_d      = N'(phase_mass(phase_d));
        prop_d        = N'(phase_prop(phase_d));
        burntime_d    = N'(phase_burn(phase_d));
        stage_d       = {1'b0, phase_d};
      end
      ST_BURN: begin
        calc_resetb_d = 1'b1;
        burning_d     = 1'b1;
      end
      ST_SEP: begin
        calc_resetb_d = 1'b1;
        if (state_q == ST_BURN) begin
          leo_pulse_d = (phase_q == 3'd3);
          sep_pulse_d = (phase_q != 3'd3);
        end else begin
          leo_pulse_d = 1'b0;
          sep_pulse_d = 1'b0;
        end
      end
      ST_DONE: begin
        calc_resetb_d = 1'b1;
        done_d        = 1'b1;
      end
      ST_FAULT: begin
        calc_resetb_d = 1'b0;
        fault_d       = 1'b1;
        stage_d       = STAGE_FAULT;
      end
      default: begin
        calc_resetb_d = 1'b0;
        fault_d       = 1'b1;
        stage_d       = STAGE_FAULT;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      state_q       <= ST_IDLE;
      phase_q       <= 3'd0;
      sep_cnt_q     <= {SW{1'b0}};
      burn_arm_q    <= 1'b0;
      calc_resetb_q <= 1'b0;
      isp_q         <= '0;
      weight_q      <= '0;
      prop_q        <= '0;
      burntime_q    <= ONE_N;
      stage_q       <= STAGE_IDLE;
      burning_q     <= 1'b0;
      sep_pulse_q   <= 1'b0;
      leo_pulse_q   <= 1'b0;
      done_q        <= 1'b0;
      fault_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      phase_q       <= phase_d;
      sep_cnt_q     <= sep_cnt_d;
      burn_arm_q    <= burn_arm_d;
      calc_resetb_q <= calc_resetb_d;
      isp_q         <= isp_d;
      weight_q      <= weight_d;
      prop_q        <= prop_d;
      burntime_q    <= burntime_d;
      stage_q       <= stage_d;
      burning_q     <= burning_d;
      sep_pulse_q   <= sep_pulse_d;
      leo_pulse_q   <= leo_pulse_d;
      done_q        <= done_d;
      fault_q       <= fault_d;
    end
  end

  assign bus.calc_resetb       = calc_resetb_q;
  assign bus.specific_impulse  = isp_q;
  assign bus.initial_weight    = weight_q;
  assign bus.propellant_weight = prop_q;
  assign bus.burntime          = burntime_q;
  assign bus.stage_state       = stage_q;
  assign bus.burning           = burning_q;
  assign bus.separate_pulse    = sep_pulse_q;
  assign bus.leo_pulse         = leo_pulse_q;
  assign bus.mission_done      = done_q;
  assign bus.fault             = fault_q;
  assign bus.mission_sec       = mission_sec_s;
endmodule

// File: tb/tb_stage_sequencer.sv
// Randomized bench for stage_sequencer: each mission is planned as a timeline of phase
// intervals (LOAD, BURN, SEP edges) and every cycle is checked against that plan.
module tb_stage_sequencer;

  localparam int T    = 4;
  localparam int SEPC = 2;

  logic clk    = 1'b0;
  logic resetb = 1'b0;
  always #5 clk = ~clk;

  stage_sequencer_if bus ();

  stage_sequencer #(
    .TICKS_PER_SEC (T),
    .SEP_CYCLES    (SEPC),
    .WDOG_SLACK    (5)
  ) dut (
    .clk    (clk),
    .resetb (resetb),
    .bus    (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  int unsigned isp_t  [1:4] = '{263, 421, 421, 421};
  int unsigned mass_t [1:4] = '{2875403, 661403, 165203, 126067};
  int unsigned prop_t [1:4] = '{2077000, 456100, 39136, 83864};
  int unsigned burn_t [1:4] = '{168, 360, 165, 335};

  // Mission plan, edges counted from the launch-sampling edge (edge 0).
  int d     [1:4];
  int L     [1:5];
  int S     [1:4];
  bit decoy [1:4];
  int D, A, ldecoy;
  bit hold2;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  function automatic void plan();
    L[1] = 0;
    for (int k = 1; k <= 4; k++) begin
      S[k]     = L[k] + d[k] + 1;
      L[k + 1] = S[k] + SEPC;
    end
    D = L[5];
  endfunction

  function automatic bit ig_at(input int e);
    for (int k = 1; k <= 4; k++) begin
      if (e == S[k]) return 1'b1;
      if (decoy[k] && e == L[k] + 2) return 1'b1;
    end
    if (hold2 && e >= S[1] && e <= S[2]) return 1'b1;
    return 1'b0;
  endfunction

  task automatic check_idle(input string tag);
    check_val({tag, " stage"}, 64'(bus.stage_state), 64'd0);
    check_val({tag, " calc_resetb"}, 64'(bus.calc_resetb), 64'd0);
    check_val({tag, " isp"}, bus.specific_impulse, 64'd0);
    check_val({tag, " weight"}, bus.initial_weight, 64'd0);
    check_val({tag, " prop"}, bus.propellant_weight, 64'd0);
    check_val({tag, " burntime"}, bus.burntime, 64'd1);
    check_val({tag, " flags"}, 64'({bus.burning, bus.separate_pulse, bus.leo_pulse,
                                     bus.mission_done, bus.fault}), 64'd0);
    check_val({tag, " msec"}, bus.mission_sec, 64'd0);
  endtask

  task automatic check_cycle(input int r);
    int stop, pr, k, msec;
    logic [3:0] e_stage;
    logic e_calc, e_burn, e_sep, e_leo, e_done, e_fault;
    stop = (A >= 0) ? A : D;
    pr   = (r < stop) ? r : stop - 1;
    k    = 1;
    for (int j = 2; j <= 4; j++) if (L[j] <= pr) k = j;
    e_burn = 1'b0; e_sep = 1'b0; e_leo = 1'b0; e_done = 1'b0; e_fault = 1'b0;
    if (r < stop) begin
      e_stage = 4'(k);
      e_calc  = (r != L[k]);
      e_burn  = (r > L[k]) && (r < S[k]);
      e_sep   = (r == S[k]) && (k != 3);
      e_leo   = (r == S[k]) && (k == 3);
    end else if (A >= 0) begin
      e_stage = 4'd15; e_calc = 1'b0; e_fault = 1'b1;
    end else begin
      e_stage = 4'd4;  e_calc = 1'b1; e_done = 1'b1;
    end
    msec = ((r < stop) ? r : stop) / T;
    check_val($sformatf("stage@%0d", r), 64'(bus.stage_state), 64'(e_stage));
    check_val($sformatf("calc_resetb@%0d", r), 64'(bus.calc_resetb), 64'(e_calc));
    check_val($sformatf("burning@%0d", r), 64'(bus.burning), 64'(e_burn));
    check_val($sformatf("sep_pulse@%0d", r), 64'(bus.separate_pulse), 64'(e_sep));
    check_val($sformatf("leo_pulse@%0d", r), 64'(bus.leo_pulse), 64'(e_leo));
    check_val($sformatf("done@%0d", r), 64'(bus.mission_done), 64'(e_done));
    check_val($sformatf("fault@%0d", r), 64'(bus.fault), 64'(e_fault));
    check_val($sformatf("msec@%0d", r), bus.mission_sec, 64'(msec));
    check_val($sformatf("isp@%0d", r), bus.specific_impulse, 64'(isp_t[k]));
    check_val($sformatf("weight@%0d", r), bus.initial_weight, 64'(mass_t[k]));
    check_val($sformatf("prop@%0d", r), bus.propellant_weight, 64'(prop_t[k]));
    check_val($sformatf("burntime@%0d", r), bus.burntime, 64'(burn_t[k]));
  endtask

  task automatic set_mission(input int fixed_d, input bit held);
    for (int k = 1; k <= 4; k++) begin
      d[k]     = (fixed_d > 0) ? fixed_d : int'($urandom_range(2, 14));
      decoy[k] = (fixed_d > 0) ? 1'b0 : 1'($urandom_range(0, 1));
    end
    hold2 = held;
    if (held) d[2] = 2;
  endtask

  // abort_mode: 0 none, 1..4 abort together with that phase's ignition_end, 5 random edge.
  task automatic run_mission(input int abort_mode, input bit cut_p2);
    int rend, w;
    plan();
    if (abort_mode == 0)      A = -1;
    else if (abort_mode <= 4) A = S[abort_mode];
    else                      A = int'($urandom_range(1, D - 1));
    ldecoy = int'($urandom_range(1, D));
    w = int'($urandom_range(1, 4));
    for (int i = 0; i < w; i++) begin
      bus.abort = (i == 0);
      @(posedge clk); @(negedge clk);
      check_idle("idle");
    end
    bus.abort = 1'b0;
    rend = ((A >= 0) ? A : D) + 4;
    if (cut_p2) rend = L[2] + 3;
    for (int r = 0; r <= rend; r++) begin
      bus.launch       = (r == 0) || (r == ldecoy);
      bus.abort        = (r == A);
      bus.ignition_end = ig_at(r);
      @(posedge clk); @(negedge clk);
      check_cycle(r);
    end
    bus.launch = 1'b0; bus.abort = 1'b0; bus.ignition_end = 1'b0;
  endtask

  task automatic do_reset();
    bus.launch = 1'b0; bus.abort = 1'b0; bus.ignition_end = 1'b0;
    resetb = 1'b0;
    @(negedge clk); @(negedge clk);
    resetb = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    bus.launch = 1'b0; bus.abort = 1'b0; bus.ignition_end = 1'b0;
    repeat (3) @(negedge clk);
    check_idle("reset");
    resetb = 1'b1;
    @(negedge clk);

    // Nominal mission, ignition_end 10 cycles into each BURN.
    A = -1; set_mission(10, 1'b0); run_mission(0, 1'b0); do_reset();
    // ignition_end held high from phase-1 SEP through phase-2 LOAD and first BURN cycles.
    set_mission(0, 1'b1); run_mission(0, 1'b0); do_reset();
    for (int i = 0; i < 3; i++) begin
      set_mission(0, 1'b0); run_mission(0, 1'b0); do_reset();
    end
    // abort coincident with ignition_end, then aborts at random edges.
    set_mission(0, 1'b0); run_mission(int'($urandom_range(1, 4)), 1'b0); do_reset();
    for (int i = 0; i < 2; i++) begin
      set_mission(0, 1'b0); run_mission(5, 1'b0); do_reset();
    end

    // Asynchronous reset in the middle of the phase-2 burn, then relaunch.
    set_mission(0, 1'b0); run_mission(0, 1'b1);
    @(posedge clk); #2 resetb = 1'b0; #1;
    check_val("async calc_resetb", 64'(bus.calc_resetb), 64'd0);
    check_val("async stage", 64'(bus.stage_state), 64'd0);
    check_val("async burning", 64'(bus.burning), 64'd0);
    check_val("async isp", bus.specific_impulse, 64'd0);
    check_val("async burntime", bus.burntime, 64'd1);
    check_val("async msec", bus.mission_sec, 64'd0);
    @(negedge clk); resetb = 1'b1; @(negedge clk);
    set_mission(0, 1'b0); run_mission(0, 1'b0); do_reset();

    // Phase-1 burn that never reports completion.
    for (int r = 0; r <= 700; r++) begin
      bus.launch = (r == 0);
      @(posedge clk); @(negedge clk);
      if (r == 690) begin
        check_val("wdog early stage", 64'(bus.stage_state), 64'd1);
        check_val("wdog early burning", 64'(bus.burning), 64'd1);
      end
      if (r == 700) begin
`ifdef STAGE_SEQ_WATCHDOG_EN
        check_val("wdog stage", 64'(bus.stage_state), 64'd15);
        check_val("wdog fault", 64'(bus.fault), 64'd1);
        check_val("wdog calc_resetb", 64'(bus.calc_resetb), 64'd0);
        check_val("wdog burning", 64'(bus.burning), 64'd0);
`else
        check_val("nowdog stage", 64'(bus.stage_state), 64'd1);
        check_val("nowdog burning", 64'(bus.burning), 64'd1);
        check_val("nowdog fault", 64'(bus.fault), 64'd0);
`endif
      end
    end
    do_reset();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
